// File: rtl/controller_responder_pkg.sv
// Shared definitions for the controller serial responder and the host-side controller.
// Button bit positions here fix the on-wire bit order for both ends of the link.
package controller_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int NUM_BUTTONS        = 12;
   localparam int DEFAULT_FRAME_BITS = 16;
   localparam int BIT_INDEX_W        = 5;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   // The serial line is active-low: a pressed button is driven as 0.
   function automatic logic [NUM_BUTTONS-1:0] buttons_to_line(input logic [NUM_BUTTONS-1:0] b);
      return ~b;
   endfunction

endpackage

// File: rtl/controller_responder_if.sv
// Host port bundle between the console-side controller and the responder.
interface controller_responder_if;
   import controller_responder_pkg::*;

   logic [NUM_BUTTONS-1:0] I_BUTTONS;
   logic                   I_CONTROLLER_LATCH;
   logic                   I_CONTROLLER_PULSE;
   logic                   O_CONTROLLER_DATA;
   logic                   O_BUSY;
   logic                   O_FRAME_DONE;
   logic [BIT_INDEX_W-1:0] O_BIT_INDEX;

   modport master (
      output I_BUTTONS, I_CONTROLLER_LATCH, I_CONTROLLER_PULSE,
      input  O_CONTROLLER_DATA, O_BUSY, O_FRAME_DONE, O_BIT_INDEX
   );

   modport slave (
      input  I_BUTTONS, I_CONTROLLER_LATCH, I_CONTROLLER_PULSE,
      output O_CONTROLLER_DATA, O_BUSY, O_FRAME_DONE, O_BIT_INDEX
   );
endinterface

// File: rtl/controller_responder_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a one-flop rise detector.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = din;
      prev_d    = level;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
endmodule

// File: rtl/controller_responder.sv
// Serial game-controller responder: latches the button state on LATCH and shifts it
// out active-low, one bit per PULSE rise, with a watchdog that abandons stalled frames.
module controller_responder
   import controller_responder_pkg::*;
#(
   parameter int FRAME_BITS     = DEFAULT_FRAME_BITS,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  I_CLK,
   input  logic                  I_ASYNC_RESET_L,
   controller_responder_if.slave bus
);
   localparam int                     TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0]        TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BIT_INDEX_W-1:0] IDX_LAST = BIT_INDEX_W'(FRAME_BITS - 1);
   localparam logic [BIT_INDEX_W-1:0] IDX_END  = BIT_INDEX_W'(FRAME_BITS);

   logic latch_level, latch_rise, pulse_rise, pulse_level_unused;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
      .clk   (I_CLK),
      .rst_n (I_ASYNC_RESET_L),
      .din   (bus.I_CONTROLLER_LATCH),
      .level (latch_level),
      .rise  (latch_rise)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
      .clk   (I_CLK),
      .rst_n (I_ASYNC_RESET_L),
      .din   (bus.I_CONTROLLER_PULSE),
      .level (pulse_level_unused),
      .rise  (pulse_rise)
   );

   state_e                 state_q, state_d;
   logic [FRAME_BITS-1:0]  sr_q, sr_d, frame_load;
   logic [BIT_INDEX_W-1:0] idx_q, idx_d;
   logic [TO_W-1:0]        to_q, to_d;
   logic                   data_q, data_d;
   logic                   done_q, done_d;
   logic                   busy;

   always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_L) begin
      if (!I_ASYNC_RESET_L) begin
         state_q <= ST_IDLE;
         sr_q    <= '1;
         idx_q   <= '0;
         to_q    <= '0;
         data_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         idx_q   <= idx_d;
         to_q    <= to_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   // Padding bits above the buttons read as released (1) on the line.
   always_comb begin
      frame_load                  = '1;
      frame_load[NUM_BUTTONS-1:0] = buttons_to_line(bus.I_BUTTONS);
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      idx_d   = idx_q;
      to_d    = '0;
      done_d  = 1'b0;
      // A LATCH rise wins over everything, including a coincident PULSE rise.
      if (latch_rise) begin
         state_d = ST_LOADED;
         sr_d    = frame_load;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: idx_d = '0;
            ST_LOADED: begin
               idx_d = '0;
               if (latch_level) sr_d = frame_load;
               else             state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (pulse_rise) begin
                  sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
                  if (idx_q >= IDX_LAST) begin
                     state_d = ST_DONE;
                     idx_d   = IDX_END;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else if (to_q == TO_LAST) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  sr_d    = '1;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (to_q == TO_LAST) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  sr_d    = '1;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      case (state_d)
         ST_LOADED, ST_SHIFT: data_d = sr_d[0];
         ST_DONE:             data_d = 1'b0;
         default:             data_d = 1'b1;
      endcase
   end

   always_comb begin
      busy                  = (state_q == ST_LOADED) || (state_q == ST_SHIFT);
      bus.O_BUSY            = busy;
      bus.O_CONTROLLER_DATA = data_q;
      bus.O_FRAME_DONE      = done_q;
      bus.O_BIT_INDEX       = idx_q;
   end
endmodule

// File: tb/tb_controller_responder.sv
// Bench for controller_responder: table of frames plus hand-written corner sequences,
// with a scoreboard of expected serial bits checked after each PULSE settles.
module tb_controller_responder;
   logic clk;
   logic rst_n;

   controller_responder_if ctrl();

   controller_responder #(
      .FRAME_BITS     (16),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .I_CLK           (clk),
      .I_ASYNC_RESET_L (rst_n),
      .bus             (ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       data;
      logic [4:0] idx;
   } exp_t;

   typedef struct {
      logic [11:0] btn_start;
      logic [11:0] btn_latch;
      logic [11:0] btn_after;
      logic [15:0] exp_bits;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[5];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   done_count = 0;

   always @(negedge clk) begin
      if (ctrl.O_FRAME_DONE === 1'b1) done_count++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic pulse_bit(input logic exp_data, input logic [4:0] exp_idx);
      exp_t e;
      e.data = exp_data;
      e.idx  = exp_idx;
      sb_q.push_back(e);
      ctrl.I_CONTROLLER_PULSE = 1'b1;
      tick(); tick();
      ctrl.I_CONTROLLER_PULSE = 1'b0;
      tick(); tick();
      e = sb_q.pop_front();
      check("bit_data", 32'(ctrl.O_CONTROLLER_DATA), 32'(e.data));
      check("bit_index", 32'(ctrl.O_BIT_INDEX), 32'(e.idx));
   endtask

   // Latch phase: buttons change mid-latch, then after the frame is frozen.
   task automatic start_frame(input logic [11:0] b_start, input logic [11:0] b_latch,
                              input logic [11:0] b_after, input logic exp_bit0);
      ctrl.I_BUTTONS = b_start;
      ctrl.I_CONTROLLER_LATCH = 1'b1;
      repeat (6) tick();
      ctrl.I_BUTTONS = b_latch;
      repeat (6) tick();
      ctrl.I_CONTROLLER_LATCH = 1'b0;
      repeat (4) tick();
      ctrl.I_BUTTONS = b_after;
      check("shift_busy", 32'(ctrl.O_BUSY), 32'd1);
      check("shift_index0", 32'(ctrl.O_BIT_INDEX), 32'd0);
      check("shift_bit0", 32'(ctrl.O_CONTROLLER_DATA), 32'(exp_bit0));
   endtask

   task automatic finish_frame(input logic [15:0] exp_bits, input int first);
      int d0;
      d0 = done_count;
      for (int k = first; k < 16; k++) pulse_bit(exp_bits[k], 5'(k));
      check("frame_no_early_done", 32'(done_count - d0), 32'd0);
      pulse_bit(1'b0, 5'd16);
      check("done_busy", 32'(ctrl.O_BUSY), 32'd0);
      check("done_pulse_count", 32'(done_count - d0), 32'd1);
      pulse_bit(1'b0, 5'd16);
      check("done_pulse_count_after", 32'(done_count - d0), 32'd1);
   endtask

   initial begin
      logic [15:0] bits;
      int          d0;

      vecs[0] = '{12'h001, 12'h001, 12'h001, 16'hFFFE};
      vecs[1] = '{12'h000, 12'hFFF, 12'h000, 16'hF000};
      vecs[2] = '{12'h000, 12'h000, 12'hFFF, 16'hFFFF};
      vecs[3] = '{12'hA5C, 12'hA5C, 12'h000, 16'hF5A3};
      vecs[4] = '{12'h800, 12'h800, 12'h800, 16'hF7FF};

      ctrl.I_BUTTONS          = 12'h000;
      ctrl.I_CONTROLLER_LATCH = 1'b0;
      ctrl.I_CONTROLLER_PULSE = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset_data", 32'(ctrl.O_CONTROLLER_DATA), 32'd1);
      check("reset_busy", 32'(ctrl.O_BUSY), 32'd0);
      check("reset_done", 32'(ctrl.O_FRAME_DONE), 32'd0);
      check("reset_index", 32'(ctrl.O_BIT_INDEX), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle_busy", 32'(ctrl.O_BUSY), 32'd0);
      pulse_bit(1'b1, 5'd0);
      $display("reset/idle: data=%0b busy=%0b", ctrl.O_CONTROLLER_DATA, ctrl.O_BUSY);

      for (int v = 0; v < 5; v++) begin
         bits = vecs[v].exp_bits;
         start_frame(vecs[v].btn_start, vecs[v].btn_latch, vecs[v].btn_after, bits[0]);
         finish_frame(bits, 1);
         $display("frame %0d: latched=%03h expected=%04h", v, vecs[v].btn_latch, bits);
      end

      // Re-latch after 5 bits restarts the frame from bit 0.
      start_frame(12'h000, 12'h000, 12'h000, 1'b1);
      for (int k = 1; k <= 5; k++) pulse_bit(1'b1, 5'(k));
      d0 = done_count;
      ctrl.I_BUTTONS = 12'h001;
      ctrl.I_CONTROLLER_LATCH = 1'b1;
      repeat (3) tick();
      check("relatch_busy", 32'(ctrl.O_BUSY), 32'd1);
      check("relatch_index", 32'(ctrl.O_BIT_INDEX), 32'd0);
      check("relatch_bit0", 32'(ctrl.O_CONTROLLER_DATA), 32'd0);
      check("relatch_no_done", 32'(done_count - d0), 32'd0);
      repeat (9) tick();
      ctrl.I_CONTROLLER_LATCH = 1'b0;
      repeat (4) tick();
      check("relatch_shift_bit0", 32'(ctrl.O_CONTROLLER_DATA), 32'd0);
      finish_frame(16'hFFFE, 1);
      $display("relatch after 5 bits: restarted frame");

      // Coincident LATCH and PULSE rise while shifting: the pulse is dropped.
      start_frame(12'h000, 12'h000, 12'h000, 1'b1);
      pulse_bit(1'b1, 5'd1);
      pulse_bit(1'b1, 5'd2);
      ctrl.I_BUTTONS = 12'h001;
      ctrl.I_CONTROLLER_LATCH = 1'b1;
      ctrl.I_CONTROLLER_PULSE = 1'b1;
      repeat (3) tick();
      check("coinc_index", 32'(ctrl.O_BIT_INDEX), 32'd0);
      check("coinc_busy", 32'(ctrl.O_BUSY), 32'd1);
      check("coinc_bit0", 32'(ctrl.O_CONTROLLER_DATA), 32'd0);
      repeat (3) tick();
      ctrl.I_CONTROLLER_PULSE = 1'b0;
      check("coinc_index_hold", 32'(ctrl.O_BIT_INDEX), 32'd0);
      repeat (6) tick();
      ctrl.I_CONTROLLER_LATCH = 1'b0;
      repeat (4) tick();
      check("coinc_shift_index", 32'(ctrl.O_BIT_INDEX), 32'd0);
      finish_frame(16'hFFFE, 1);
      $display("coincident latch/pulse: reload with index 0");

      // Watchdog: stall after 3 bits, IDLE exactly 64 cycles after the last shift.
      start_frame(12'h000, 12'h000, 12'h000, 1'b1);
      d0 = done_count;
      for (int k = 1; k <= 3; k++) pulse_bit(1'b1, 5'(k));
      repeat (62) tick();
      check("timeout_busy_before", 32'(ctrl.O_BUSY), 32'd1);
      tick();
      check("timeout_busy", 32'(ctrl.O_BUSY), 32'd0);
      check("timeout_data", 32'(ctrl.O_CONTROLLER_DATA), 32'd1);
      check("timeout_index", 32'(ctrl.O_BIT_INDEX), 32'd0);
      check("timeout_no_done", 32'(done_count - d0), 32'd0);
      pulse_bit(1'b1, 5'd0);
      $display("timeout after 3 bits: back to idle");

      // Asynchronous reset at bit 7, then a full clean frame.
      start_frame(12'h0F0, 12'h0F0, 12'h0F0, 1'b1);
      bits = 16'hFF0F;
      for (int k = 1; k <= 7; k++) pulse_bit(bits[k], 5'(k));
      #3 rst_n = 1'b0;
      #1;
      check("midreset_data", 32'(ctrl.O_CONTROLLER_DATA), 32'd1);
      check("midreset_busy", 32'(ctrl.O_BUSY), 32'd0);
      check("midreset_done", 32'(ctrl.O_FRAME_DONE), 32'd0);
      check("midreset_index", 32'(ctrl.O_BIT_INDEX), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("postreset_busy", 32'(ctrl.O_BUSY), 32'd0);
      check("postreset_data", 32'(ctrl.O_CONTROLLER_DATA), 32'd1);
      pulse_bit(1'b1, 5'd0);
      start_frame(vecs[0].btn_start, vecs[0].btn_latch, vecs[0].btn_after, 1'b0);
      finish_frame(vecs[0].exp_bits, 1);
      $display("reset at bit 7: recovered with full frame");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/controller_responder.md
CONTROLLER_RESPONDER -- requirements
Module: controller_responder

Interface
REQ-001 Parameter FRAME_BITS, default 16, number of serial bits per frame (12 button bits, then padding).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on LATCH and PULSE inputs.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, I_CLK cycles without PULSE activity before an in-progress frame is abandoned.
REQ-004 I_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 I_ASYNC_RESET_L  input  1  asynchronous, active-low reset.
REQ-006 I_BUTTONS  input  12  live button state, 1 = pressed; bit order B,Y,SELECT,START,UP,DOWN,LEFT,RIGHT,A,X,L,R (bit0 = B).
REQ-007 I_CONTROLLER_LATCH  input  1  asynchronous latch strobe from the host controller port, active-high.
REQ-008 I_CONTROLLER_PULSE  input  1  asynchronous shift clock from the host; a rising edge advances one bit.
REQ-009 O_CONTROLLER_DATA  output  1  registered serial data, active-low (0 = pressed).
REQ-010 O_BUSY  output  1  high in states LOADED and SHIFT.
REQ-011 O_FRAME_DONE  output  1  one-cycle pulse when the last frame bit has been shifted past.
REQ-012 O_BIT_INDEX  output  5  index of the bit currently presented on O_CONTROLLER_DATA.

Function
REQ-013 LATCH and PULSE each pass through a SYNC_STAGES flop chain, then a 1-flop rising-edge detector; the total pin-to-O_CONTROLLER_DATA latency is SYNC_STAGES+1 cycles.
REQ-014 The states are IDLE, LOADED, SHIFT and DONE.
REQ-015 IDLE: O_CONTROLLER_DATA = 1 and O_BIT_INDEX = 0; a synchronized LATCH rise transitions to LOADED.
REQ-016 LOADED: the shift register captures {4'b1111 padding, ~I_BUTTONS} on every cycle while LATCH is high; O_CONTROLLER_DATA = bit0, O_BIT_INDEX = 0; PULSE edges are ignored.
REQ-017 LOADED -> SHIFT on the synchronized LATCH fall; the captured value is frozen from that cycle.
REQ-018 SHIFT: each synchronized PULSE rise shifts right by one and increments O_BIT_INDEX; the new bit appears on O_CONTROLLER_DATA in the same registered update.
REQ-019 SHIFT -> DONE on the PULSE rise that takes O_BIT_INDEX from FRAME_BITS-1 to FRAME_BITS; O_FRAME_DONE pulses in that cycle.
REQ-020 DONE: O_CONTROLLER_DATA = 0 (line held low after the frame); further PULSE edges have no effect; O_BIT_INDEX saturates at FRAME_BITS.
REQ-021 From SHIFT or DONE, a synchronized LATCH rise transitions to LOADED and restarts the frame.
REQ-022 When a LATCH rise and a PULSE rise are detected in the same cycle, LATCH takes priority and the PULSE rise is dropped.
REQ-023 In SHIFT, the timeout counter resets on every PULSE rise; reaching TIMEOUT_CYCLES-1 transitions to IDLE with no O_FRAME_DONE.
REQ-024 In DONE, the timeout counter returns the block to IDLE in the same way.
REQ-025 The timeout counter is clog2(TIMEOUT_CYCLES) bits wide and does not wrap.
REQ-026 A glitch on LATCH or PULSE shorter than one I_CLK period has no required effect, but the block never leaves the defined states.

Reset
REQ-027 Asserting I_ASYNC_RESET_L low immediately forces: state IDLE, O_CONTROLLER_DATA = 1, O_BUSY = 0, O_FRAME_DONE = 0, O_BIT_INDEX = 0, shift register all ones, synchronizers 0, timeout counter 0.
REQ-028 Reset asserted mid-frame discards the frame; after release, the next LATCH rise is required before any data is driven.
REQ-029 Reset deassertion does not by itself create a LATCH or PULSE edge.

Structure
REQ-030 The state encoding, the default FRAME_BITS value and the button bit-position constants belong in the shared controller package, so the host-side controller uses the same bit order.
REQ-031 One sub-module, sync_edge_detect (parameter SYNC_STAGES; outputs the synchronized level and a rise pulse), is instantiated once for LATCH and once for PULSE.

Verification
REQ-032 Buttons = 12'h001 (B); LATCH high for 12 cycles then low; 16 PULSE rises -> DATA sequence 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1, then 0; O_FRAME_DONE pulses exactly once.
REQ-033 Buttons change from 12'h000 to 12'hFFF while LATCH is high, then back to 12'h000 after the LATCH fall -> bits 0-11 all read 0 and bits 12-15 read 1.
REQ-034 After 5 PULSE rises, assert LATCH again -> state LOADED, O_BIT_INDEX = 0, no O_FRAME_DONE, and the frame restarts from bit0.
REQ-035 LATCH and PULSE rise on the same I_CLK edge while in SHIFT -> reload occurs and O_BIT_INDEX = 0, not 1.
REQ-036 TIMEOUT_CYCLES = 64; stop PULSE after 3 bits -> IDLE exactly 64 cycles after the last PULSE rise, DATA = 1, O_BUSY = 0.
REQ-037 Assert reset at bit 7 -> all outputs take their reset values asynchronously; a following full frame is correct.
